// File: rtl/axi_lite_msg_queue.sv
// axi_lite_msg_queue: AXI4-Lite slave FIFO message queue with a level-threshold interrupt.
// Writers push 32-bit words into DATA and readers pop them in FIFO order.
//
// Register map (addr[3:2]):
//   0x0 DATA   : a write pushes a word, a read pops the head.
//   0x4 STATUS : [0] empty, [1] full, [2] ovf (sticky), [15:8] count.
//   0x8 THRESH : [7:0] interrupt threshold.
//   0xC CTRL   : [1] irq_en; writing [0]=1 flushes the queue.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   aw*/w*/b* (awaddr_i ..)    AXI-Lite write address/data/response channels
//   ar*/r*    (araddr_i ..)    AXI-Lite read address/data channels
//   irq_o                      registered level interrupt
//
// Optional macro MSGQ_OVERFLOW_IRQ_EN: when defined, irq_o also asserts
// (gated by irq_en) while the sticky overflow flag is set.

module axi_lite_msg_queue #(
    parameter int unsigned Depth     = 8,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] awaddr_i,
    input  logic                 awvalid_i,
    output logic                 awready_o,
    input  logic [31:0]          wdata_i,
    input  logic [3:0]           wstrb_i,
    input  logic                 wvalid_i,
    output logic                 wready_o,
    output logic [1:0]           bresp_o,
    output logic                 bvalid_o,
    input  logic                 bready_i,
    input  logic [AddrWidth-1:0] araddr_i,
    input  logic                 arvalid_i,
    output logic                 arready_o,
    output logic [31:0]          rdata_o,
    output logic [1:0]           rresp_o,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic                 irq_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(Depth);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    if (DataWidth != 32) begin : g_dw_check
        $error("axi_lite_msg_queue: DataWidth must be 32");
    end
    if (Depth < 2 || Depth > 128 || (Depth & (Depth - 1)) != 0) begin : g_depth_check
        $error("axi_lite_msg_queue: Depth must be a power of 2 in 2..128");
    end

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_e;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;

    logic [31:0]     mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      thresh_q, thresh_d;
    logic            irq_en_q, irq_en_d;
    logic            ovf_q, ovf_d;
    logic            irq_q, irq_d;
    logic [1:0]      bresp_q, bresp_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [31:0]     rdata_q, rdata_d;

    logic        full, empty;
    logic        aw_hs, ar_hs;
    logic        strb_ok;
    logic [1:0]  wr_sel, rd_sel;
    logic        push, pop, ovf_set, flush;
    logic        thr_we, ctrl_we;
    logic [1:0]  wr_resp;
    logic [31:0] rd_val;
    logic [1:0]  rd_resp;
    logic        rd_pop;
    logic [7:0]  cnt8_q, cnt8_d;
    logic        thr_hit;

    // Only addr[3:2] is decoded; the crossbar handles region routing.
    logic unused_addr;
    assign unused_addr = ^{awaddr_i, araddr_i};

    // Full/empty always come from the pre-edge count.
    assign full    = (count_q == DepthC);
    assign empty   = (count_q == '0);
    assign cnt8_q  = 8'(count_q);
    assign strb_ok = (wstrb_i == 4'hF);
    assign wr_sel  = awaddr_i[3:2];
    assign rd_sel  = araddr_i[3:2];

    // ---------------- write channel ----------------
    always_comb begin
        wstate_d = wstate_q;
        aw_hs    = 1'b0;
        bresp_d  = bresp_q;
        unique case (wstate_q)
            W_IDLE: begin
                if (awvalid_i && wvalid_i && !rst_i) begin
                    aw_hs    = 1'b1;
                    bresp_d  = wr_resp;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready_i) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    assign awready_o = aw_hs;
    assign wready_o  = aw_hs;
    assign bvalid_o  = (wstate_q == W_RESP);
    assign bresp_o   = bresp_q;

    always_comb begin
        push    = 1'b0;
        ovf_set = 1'b0;
        thr_we  = 1'b0;
        ctrl_we = 1'b0;
        wr_resp = RespOkay;
        if (!strb_ok) begin
            wr_resp = RespSlvErr;
        end else begin
            unique case (wr_sel)
                2'd0: begin
                    // A full queue drops the push even if a same-cycle pop frees space.
                    if (full) begin
                        wr_resp = RespSlvErr;
                        ovf_set = aw_hs;
                    end else begin
                        push = aw_hs;
                    end
                end
                2'd1: ;
                2'd2: thr_we  = aw_hs;
                2'd3: ctrl_we = aw_hs;
            endcase
        end
    end

    assign flush = ctrl_we & wdata_i[0];

    // ---------------- read channel ----------------
    always_comb begin
        rd_val  = '0;
        rd_resp = RespOkay;
        rd_pop  = 1'b0;
        unique case (rd_sel)
            2'd0: begin
                if (empty) begin
                    rd_resp = RespSlvErr;
                end else begin
                    rd_val = mem_q[rd_ptr_q];
                    rd_pop = 1'b1;
                end
            end
            2'd1: rd_val = {16'h0, cnt8_q, 5'h0, ovf_q, full, empty};
            2'd2: rd_val = {24'h0, thresh_q};
            2'd3: rd_val = {30'h0, irq_en_q, 1'b0};
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        ar_hs    = 1'b0;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (arvalid_i && !rst_i) begin
                    ar_hs    = 1'b1;
                    rdata_d  = rd_val;
                    rresp_d  = rd_resp;
                    rstate_d = R_RESP;
                end
            end
            R_RESP: begin
                if (rready_i) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    assign pop       = ar_hs & rd_pop;
    assign arready_o = (rstate_q == R_IDLE) && !rst_i;
    assign rvalid_o  = (rstate_q == R_RESP);
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

    // ---------------- queue state ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);
        ovf_d    = ovf_q;
        thresh_d = thresh_q;
        irq_en_d = irq_en_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
        if (thr_we) begin
            thresh_d = wdata_i[7:0];
        end
        if (ctrl_we) begin
            irq_en_d = wdata_i[1];
        end
        // Flush wins; a same-cycle pop still returns its data.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end
    end

    assign cnt8_d  = 8'(count_d);
    assign thr_hit = (thresh_d != 8'h0) && (cnt8_d >= thresh_d);

`ifdef MSGQ_OVERFLOW_IRQ_EN
    assign irq_d = irq_en_d & (thr_hit | ovf_d);
`else
    assign irq_d = irq_en_d & thr_hit;
`endif

    assign irq_o = irq_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            thresh_q <= '0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            bresp_q  <= '0;
            rresp_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            thresh_q <= thresh_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            bresp_q  <= bresp_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule
